axi4_lite_regbank: RTL and testbench

AXI4_LITE_REGBANK -- requirements
Module: axi4_lite_regbank

---
 rtl/axi4_lite_pkg.sv | 14 +
 rtl/axi4_lite_addr_decode.sv | 27 ++
 rtl/axi4_lite_regbank.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_regbank.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-channel FSM states.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address -> word index, with range and read-only classification for one channel.
module axi4_lite_addr_decode #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  localparam int unsigned LSB = $clog2(DATA_W / 8),
  localparam int unsigned IDX_W = ADDR_W - LSB
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              in_range,
  output logic              read_only
);

  logic [NUM_REGS-1:0] ro_shifted;
  logic                unused_low;

  assign idx        = addr[ADDR_W-1:LSB];
  assign unused_low = ^addr[LSB-1:0];
  assign in_range   = 32'(idx) < NUM_REGS;

  // Out-of-range indices shift every mask bit away, so read_only is 0 for them.
  assign ro_shifted = RO_MASK >> idx;
  assign read_only  = ro_shifted[0];

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite register bank: independent write FSM and single-entry read path over NUM_REGS words.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [2:0]                   awprot,
  input  logic                         wrvalid,
  output logic                         wrready,
  input  logic [DATA_W-1:0]            wrdata,
  input  logic [DATA_W/8-1:0]          wrstrb,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [1:0]                   bresp,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [2:0]                   arprot,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - $clog2(STRB_W);

  wr_state_e            state, state_nx;
  logic [DATA_W-1:0]    regs [NUM_REGS];
  logic [ADDR_W-1:0]    aw_addr_q;
  logic [DATA_W-1:0]    w_data_q;
  logic [STRB_W-1:0]    w_strb_q;
  logic                 aw_hs, w_hs, ar_hs, wr_commit;
  logic [ADDR_W-1:0]    wr_addr_sel;
  logic [DATA_W-1:0]    wr_data_sel;
  logic [STRB_W-1:0]    wr_strb_sel;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 wr_in_range, wr_ro, wr_ok;
  logic                 rd_in_range, rd_ro;
  logic [DATA_W-1:0]    rd_word;
  logic                 unused_prot;

  assign unused_prot = ^{awprot, arprot};

  // Readies are masked by reset so they read 0 while reset is held, not just after the first edge.
  assign awready = !reset && (state == W_IDLE || state == W_HAVE_W);
  assign wrready = !reset && (state == W_IDLE || state == W_HAVE_AW);
  assign bvalid  = (state == W_RESP);
  assign arready = !reset && !rvalid;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wrvalid && wrready;
  assign ar_hs = arvalid && arready;

  assign wr_addr_sel = (state == W_HAVE_AW) ? aw_addr_q : awaddr;
  assign wr_data_sel = (state == W_HAVE_W)  ? w_data_q  : wrdata;
  assign wr_strb_sel = (state == W_HAVE_W)  ? w_strb_q  : wrstrb;
  assign wr_ok       = wr_in_range && !wr_ro;

  axi4_lite_addr_decode #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_wr_dec (
    .addr(wr_addr_sel), .idx(wr_idx), .in_range(wr_in_range), .read_only(wr_ro)
  );

  axi4_lite_addr_decode #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_rd_dec (
    .addr(araddr), .idx(rd_idx), .in_range(rd_in_range), .read_only(rd_ro)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= W_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_commit = 1'b0;
    case (state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
          state_nx  = W_RESP;
        end else if (aw_hs) begin
          state_nx = W_HAVE_AW;
        end else if (w_hs) begin
          state_nx = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wr_commit = 1'b1;
          state_nx  = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wr_commit = 1'b1;
          state_nx  = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) state_nx = W_IDLE;
      end
      default: state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wrdata;
        w_strb_q <= wrstrb;
      end
      if (wr_commit) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_commit && wr_ok && wr_idx == IDX_W'(i)) begin
          reg_wr_pulse[i] <= 1'b1;
          for (int unsigned b = 0; b < STRB_W; b++)
            if (wr_strb_sel[b]) regs[i][8*b +: 8] <= wr_data_sel[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs[i];
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_word = rd_ro ? ro_in[i*DATA_W +: DATA_W] : regs[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_in_range ? rd_word : '0;
      rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Randomized scoreboard bench for axi4_lite_regbank against an array-based register model.
module tb_axi4_lite_regbank;
  import axi4_lite_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 16;
  localparam logic [NR-1:0] ROM = 16'h0008;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               awvalid, awready, wrvalid, wrready, bvalid, bready;
  logic               arvalid, arready, rvalid, rready;
  logic [AW-1:0]      awaddr, araddr;
  logic [2:0]         awprot, arprot;
  logic [DW-1:0]      wrdata, rdata;
  logic [DW/8-1:0]    wrstrb;
  logic [1:0]         bresp, rresp;
  logic [NR*DW-1:0]   reg_q, ro_in;
  logic [NR-1:0]      reg_wr_pulse;

  axi4_lite_regbank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(ROM)
  ) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wrvalid(wrvalid), .wrready(wrready), .wrdata(wrdata), .wrstrb(wrstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .ro_in(ro_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       resp;
    logic [NR-1:0]    pulse;
    logic [NR*DW-1:0] regs;
  } bexp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rexp_t;

  int          tests = 0;
  int          fails = 0;
  bexp_t       bq[$];
  rexp_t       rq[$];
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] ro_mask_v;
  bit          mon_on = 0;
  bit          b_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name);
    for (int i = 0; i < int'(NR); i++)
      chk($sformatf("%s[%0d]", name, i), 64'(reg_q[i*DW +: DW]), 64'(m_regs[i]));
  endtask

  // Reference model: a write is OKAY only for an in-range, writable word; strobes pick bytes.
  task automatic exp_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bexp_t e;
    logic [5:0] idx;
    idx = a[7:2];
    e.pulse = '0;
    if (idx < 6'(NR) && !ro_mask_v[idx[3:0]]) begin
      resp = RESP_OKAY;
      for (int b = 0; b < 4; b++)
        if (s[b]) m_regs[idx[3:0]][8*b +: 8] = d[8*b +: 8];
      e.pulse[idx[3:0]] = 1'b1;
    end else begin
      resp = RESP_SLVERR;
    end
    e.resp = resp;
    for (int i = 0; i < int'(NR); i++) e.regs[i*DW +: DW] = m_regs[i];
    bq.push_back(e);
  endtask

  task automatic exp_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    rexp_t e;
    logic [5:0] idx;
    idx = a[7:2];
    if (idx >= 6'(NR)) begin
      d = '0;
      resp = RESP_SLVERR;
    end else if (ro_mask_v[idx[3:0]]) begin
      d = ro_in[32*idx[3:0] +: 32];
      resp = RESP_OKAY;
    end else begin
      d = m_regs[idx[3:0]];
      resp = RESP_OKAY;
    end
    e.data = d;
    e.resp = resp;
    rq.push_back(e);
  endtask

  // Starts and ends just after a rising edge; AW raised at cycle da, W at cycle dw.
  task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int da, input int dw, input int hold, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, aw_h, w_h;
    int cyc = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && cyc == da) begin awaddr = a; awvalid = 1'b1; end
      if (!w_done && cyc == dw) begin wrdata = d; wrstrb = s; wrvalid = 1'b1; end
      @(negedge clk);
      aw_h = awvalid && awready;
      w_h  = wrvalid && wrready;
      @(posedge clk); #1;
      if (aw_h) begin awvalid = 1'b0; aw_done = 1; awaddr = 8'($urandom); end
      if (w_h) begin wrvalid = 1'b0; w_done = 1; wrdata = $urandom; wrstrb = 4'($urandom); end
      cyc++;
      if (cyc > 40) begin
        tests++; fails++;
        $display("FAIL wr_handshake_timeout: got no handshake, expected one within 40 cycles");
        awvalid = 1'b0; wrvalid = 1'b0;
        return;
      end
    end
    bready = (hold == 0);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      chk("bvalid_up", 64'(bvalid), 64'd1);
      chk("bresp_hold", 64'(bresp), 64'(exp_resp));
      chk("awready_in_resp", 64'(awready), 64'd0);
      chk("wrready_in_resp", 64'(wrready), 64'd0);
      @(posedge clk); #1;
      if (k == hold - 1) bready = 1'b1;
    end
    bready = 1'b0;
    @(negedge clk);
    chk("bvalid_clear", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drive_read(input logic [7:0] a, input int delay, input int hold,
                            input logic [31:0] exp_d, input logic [1:0] exp_r);
    bit done = 0, h;
    int cyc = 0;
    while (!done) begin
      if (cyc == delay) begin araddr = a; arvalid = 1'b1; end
      @(negedge clk);
      h = arvalid && arready;
      @(posedge clk); #1;
      if (h) begin arvalid = 1'b0; done = 1; araddr = 8'($urandom); end
      cyc++;
      if (cyc > 40) begin
        tests++; fails++;
        $display("FAIL rd_handshake_timeout: got no handshake, expected one within 40 cycles");
        arvalid = 1'b0;
        return;
      end
    end
    rready = (hold == 0);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      chk("rvalid_up", 64'(rvalid), 64'd1);
      chk("rdata_hold", 64'(rdata), 64'(exp_d));
      chk("rresp_hold", 64'(rresp), 64'(exp_r));
      chk("arready_in_rvalid", 64'(arready), 64'd0);
      @(posedge clk); #1;
      if (k == hold - 1) rready = 1'b1;
    end
    rready = 1'b0;
    @(negedge clk);
    chk("rvalid_clear", 64'(rvalid), 64'd0);
    chk("arready_back", 64'(arready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int da, input int dw, input int hold);
    logic [1:0] r;
    exp_write(a, d, s, r);
    drive_write(a, d, s, da, dw, hold, r);
  endtask

  task automatic do_read(input logic [7:0] a, input int delay, input int hold);
    logic [31:0] d;
    logic [1:0]  r;
    exp_read(a, d, r);
    drive_read(a, delay, hold, d, r);
  endtask

  // Read expectation is taken before the write updates the model: same-edge reads see old data.
  task automatic concurrent_rw(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic [1:0]  rr, wr;
    exp_read(a, rd, rr);
    exp_write(a, d, s, wr);
    fork
      drive_read(a, 0, 0, rd, rr);
      drive_write(a, d, s, 0, 0, 0, wr);
    join
  endtask

  always @(negedge clk) begin
    bexp_t be;
    rexp_t re;
    if (mon_on) begin
      if (bvalid && !b_prev) begin
        if (bq.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_unexpected: got bvalid, expected no pending write");
        end else begin
          be = bq[0];
          chk("wr_pulse", 64'(reg_wr_pulse), 64'(be.pulse));
          for (int i = 0; i < int'(NR); i++)
            chk($sformatf("reg_q[%0d]", i), 64'(reg_q[i*DW +: DW]), 64'(be.regs[i*DW +: DW]));
        end
      end else begin
        chk("pulse_idle", 64'(reg_wr_pulse), 64'd0);
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_handshake: got response, expected none queued");
        end else begin
          be = bq.pop_front();
          chk("sb_bresp", 64'(bresp), 64'(be.resp));
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_handshake: got read data, expected none queued");
        end else begin
          re = rq.pop_front();
          chk("sb_rdata", 64'(rdata), 64'(re.data));
          chk("sb_rresp", 64'(rresp), 64'(re.resp));
        end
      end
    end
    b_prev = bvalid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of run within 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    logic [7:0] a;
    awvalid = 0; wrvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wrdata = 0; wrstrb = 0;
    awprot = 3'($urandom); arprot = 3'($urandom);
    ro_mask_v = ROM;
    for (int i = 0; i < int'(NR); i++) begin
      ro_in[i*DW +: DW] = $urandom;
      m_regs[i] = '0;
    end
    ro_in[3*DW +: DW] = 32'h1234_5678;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 mon_on = 1;
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wrready", 64'(wrready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk_regs("rst_reg_q");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_awready", 64'(awready), 64'd1);
    chk("rel_wrready", 64'(wrready), 64'd1);
    chk("rel_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;

    do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    chk("same_cycle_reg1", 64'(reg_q[1*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    do_write(8'h08, 32'hAAAA_AAAA, 4'hF, 0, 0, 1);
    do_write(8'h08, 32'h1122_3344, 4'h3, 3, 0, 0);
    chk("w_first_reg2", 64'(reg_q[2*DW +: DW]), 64'h0000_0000_AAAA_3344);
    do_write(8'h40, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    do_read(8'h40, 0, 0);
    do_write(8'h0C, 32'h5555_5555, 4'hF, 1, 0, 0);
    do_read(8'h0C, 0, 0);
    do_write(8'h14, 32'h0102_0304, 4'hF, 0, 2, 5);
    do_read(8'h14, 0, 5);
    do_write(8'h04, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    do_read(8'h07, 1, 0);
    concurrent_rw(8'h04, 32'h7777_0000, 4'hC);

    for (int n = 0; n < 90; n++) begin
      op = int'($urandom_range(0, 9));
      a  = 8'($urandom_range(0, 8'h4F));
      if (op < 5)
        do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else if (op < 9)
        do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else
        concurrent_rw(a, $urandom, 4'($urandom));
    end

    awaddr = 8'h10; awvalid = 1'b1;
    @(negedge clk);
    chk("pre_rst_awready", 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 1'b0; awaddr = '0;
    @(negedge clk);
    chk("have_aw_awready", 64'(awready), 64'd0);
    chk("have_aw_wrready", 64'(wrready), 64'd1);
    chk_regs("have_aw_reg_q");
    @(posedge clk); #1;
    reset = 1'b1; wrdata = 32'h9999_9999; wrstrb = 4'hF; wrvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_wrready", 64'(wrready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_awready", 64'(awready), 64'd0);
    chk("mid_rst_arready", 64'(arready), 64'd0);
    chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    chk_regs("mid_rst_reg_q");
    @(posedge clk); #1 reset = 1'b0; wrvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_wrready", 64'(wrready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);
    chk("post_rst_bvalid", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    do_write(8'h18, 32'h0BAD_F00D, 4'hF, 2, 0, 0);
    do_read(8'h10, 0, 0);

    for (int i = 0; i <= int'(NR); i++) do_read(8'(4 * i), 0, 0);

    repeat (2) @(posedge clk);
    chk("bq_drained", 64'(bq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
